// File: rtl/output_stream_ctrl.sv
// rtl/output_stream_ctrl.sv - frame streamer from shared RAM to a pixel FIFO with cpu/stream arbitration
module output_stream_ctrl #(
    parameter int ADDR_W    = 18,
    parameter int BASE_ADDR = 160000,
    parameter int LEN0      = 40000,
    parameter int LEN1      = 88804,
    parameter int FIFO_D    = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_sel,
    input  logic              i_abort,
    input  logic              i_cpu_req,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic              i_cpu_we,
    output logic              o_cpu_gnt,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    input  logic [7:0]        i_mem_rdata,
    output logic [7:0]        o_pix_data,
    output logic              o_pix_valid,
    input  logic              i_pix_ready,
    output logic              o_busy,
    output logic              o_done
);

    localparam int LEN_MAX = (LEN0 > LEN1) ? LEN0 : LEN1;
    localparam int CNT_W   = $clog2(LEN_MAX + 1);
    localparam int PTR_W   = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int FCNT_W  = $clog2(FIFO_D + 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [CNT_W-1:0]    r_remaining;
    logic                r_inflight;
    logic                r_rr_cpu;
    logic                r_busy;
    logic                r_done;
    logic [7:0]          r_fifo [FIFO_D];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [FCNT_W-1:0]   r_count;

    logic                w_credit;
    logic                w_stream_req;
    logic                w_contested;
    logic                w_cpu_gnt;
    logic                w_stream_gnt;
    logic                w_flush;
    logic                w_push;
    logic                w_pop;

    // Credit check, round-robin arbitration and shared memory port muxing
    always_comb begin
        w_credit     = (int'(r_count) + int'(r_inflight)) < FIFO_D;
        // A read is never issued in the abort cycle so nothing returns after the flush
        w_stream_req = (r_state == S_STREAM) && (r_remaining != '0) && w_credit && !i_abort;
        w_contested  = w_stream_req && i_cpu_req;
        w_cpu_gnt    = !i_rst && i_cpu_req && (!w_stream_req || r_rr_cpu);
        w_stream_gnt = !i_rst && w_stream_req && (!i_cpu_req || !r_rr_cpu);
        w_flush      = i_abort && ((r_state == S_STREAM) || (r_state == S_DRAIN));
        w_push       = r_inflight;
        w_pop        = (r_count != '0) && i_pix_ready;
        o_cpu_gnt    = w_cpu_gnt;
        o_mem_addr   = '0;
        o_mem_we     = 1'b0;
        if (w_cpu_gnt) begin
            o_mem_addr = i_cpu_addr;
            o_mem_we   = i_cpu_we;
        end else if (w_stream_gnt) begin
            o_mem_addr = r_rd_addr;
        end
    end

    // Frame control FSM: address/length bookkeeping, in-flight flag, arbiter pointer
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_rd_addr   <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_rr_cpu    <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_stream_gnt;
            if (w_contested) begin
                r_rr_cpu <= !r_rr_cpu;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_rd_addr   <= ADDR_W'(BASE_ADDR);
                        r_remaining <= i_sel ? CNT_W'(LEN1) : CNT_W'(LEN0);
                        r_busy      <= 1'b1;
                        r_state     <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (i_abort) begin
                        r_inflight <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (w_stream_gnt) begin
                        r_remaining <= r_remaining - 1'b1;
                        // Hold the address on the last read so it never passes the frame end
                        if (r_remaining == CNT_W'(1)) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (i_abort) begin
                        r_inflight <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (!r_inflight && (r_count == '0)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Pixel FIFO pointers and occupancy; abort empties it in one cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_D - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_D - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage captures read data the cycle after each stream read
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= i_mem_rdata;
        end
    end

    assign o_pix_valid = (r_count != '0);
    assign o_pix_data  = o_pix_valid ? r_fifo[r_rd_ptr] : 8'h00;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_output_stream_ctrl.sv
// tb/tb_output_stream_ctrl.sv - directed vector and sequence bench for output_stream_ctrl
module tb_output_stream_ctrl;

    localparam int ADDR_W = 18;
    localparam int BASE   = 160000;
    localparam int L0     = 20;
    localparam int L1     = 37;
    localparam int FD     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              sel;
    logic              abort;
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_we;
    logic              cpu_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_rdata = 8'h00;
    logic [7:0]        pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              busy;
    logic              done;

    int n_cmp  = 0;
    int n_fail = 0;
    int pix_idx, pix_err, rd_cnt, rd_max, done_cnt;

    output_stream_ctrl #(
        .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .LEN0(L0), .LEN1(L1), .FIFO_D(FD)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_sel(sel), .i_abort(abort),
        .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr), .i_cpu_we(cpu_we),
        .o_cpu_gnt(cpu_gnt), .o_mem_addr(mem_addr), .o_mem_we(mem_we),
        .i_mem_rdata(mem_rdata), .o_pix_data(pix_data), .o_pix_valid(pix_valid),
        .i_pix_ready(pix_ready), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pixf(input int a);
        return 8'((a * 13 + 7) & 255);
    endfunction

    // RAM model: read data one cycle after the address
    always @(posedge clk) mem_rdata <= pixf(int'(mem_addr));

    // Observe pops, stream reads and done pulses away from the active edge
    always @(negedge clk) begin
        if (pix_valid && pix_ready) begin
            if (pix_data != pixf(BASE + pix_idx)) pix_err++;
            pix_idx++;
        end
        if (!cpu_gnt && mem_addr != '0) begin
            rd_cnt++;
            if (int'(mem_addr) > rd_max) rd_max = int'(mem_addr);
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        pix_idx = 0; pix_err = 0; rd_cnt = 0; rd_max = 0; done_cnt = 0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_seen", int'(seen), 1);
        tick();
    endtask

    task automatic kick(input logic s);
        start = 1'b1; sel = s;
        tick();
        start = 1'b0;
    endtask

    typedef struct {
        logic              req;
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic              ab;
        logic              e_gnt;
        logic [ADDR_W-1:0] e_addr;
        logic              e_we;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{1'b1, 18'h00123, 1'b0, 1'b0, 1'b1, 18'h00123, 1'b0};
        vecs[1] = '{1'b1, 18'h3FFFF, 1'b1, 1'b0, 1'b1, 18'h3FFFF, 1'b1};
        vecs[2] = '{1'b0, 18'h15555, 1'b1, 1'b0, 1'b0, 18'h00000, 1'b0};
        vecs[3] = '{1'b1, 18'h0ABCD, 1'b1, 1'b1, 1'b1, 18'h0ABCD, 1'b1};
        vecs[4] = '{1'b0, 18'h00000, 1'b0, 1'b1, 1'b0, 18'h00000, 1'b0};
        clr();
        rst = 1'b1; start = 1'b0; sel = 1'b0; abort = 1'b0;
        cpu_req = 1'b1; cpu_addr = 18'h2AAAA; cpu_we = 1'b1; pix_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_gnt", int'(cpu_gnt), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_pix_data", int'(pix_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        rst = 1'b0;
        tick();

        // Idle-state arbitration vectors, including abort with no effect
        for (int i = 0; i < 5; i++) begin
            cpu_req = vecs[i].req; cpu_addr = vecs[i].addr;
            cpu_we = vecs[i].we; abort = vecs[i].ab;
            @(negedge clk);
            chk("vec_gnt", int'(cpu_gnt), int'(vecs[i].e_gnt));
            chk("vec_addr", int'(mem_addr), int'(vecs[i].e_addr));
            chk("vec_we", int'(mem_we), int'(vecs[i].e_we));
            tick();
            chk("vec_busy", int'(busy), 0);
            chk("vec_pix_valid", int'(pix_valid), 0);
        end
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; abort = 1'b0;

        // Frame sel=0, free-flowing
        clr();
        kick(1'b0);
        wait_done(400);
        chk("a_busy_after", int'(busy), 0);
        chk("a_done_one_cycle", int'(done), 0);
        repeat (3) tick();
        chk("a_pix_count", pix_idx, L0);
        chk("a_pix_err", pix_err, 0);
        chk("a_rd_count", rd_cnt, L0);
        chk("a_rd_max", rd_max, BASE + L0 - 1);
        chk("a_done_count", done_cnt, 1);

        // Frame sel=1 with a start during STREAM that must be ignored
        clr();
        kick(1'b1);
        repeat (5) tick();
        kick(1'b0);
        wait_done(400);
        chk("b_pix_count", pix_idx, L1);
        chk("b_pix_err", pix_err, 0);
        chk("b_rd_count", rd_cnt, L1);
        chk("b_rd_max", rd_max, BASE + L1 - 1);
        chk("b_done_count", done_cnt, 1);

        // Backpressure: reads stop at FIFO depth, head pixel held
        clr();
        pix_ready = 1'b0;
        kick(1'b0);
        repeat (20) tick();
        chk("bp_reads", rd_cnt, FD);
        chk("bp_valid", int'(pix_valid), 1);
        chk("bp_head", int'(pix_data), int'(pixf(BASE)));
        repeat (5) tick();
        chk("bp_head_stable", int'(pix_data), int'(pixf(BASE)));
        pix_ready = 1'b1;
        wait_done(400);
        chk("bp_pix_count", pix_idx, L0);
        chk("bp_pix_err", pix_err, 0);
        chk("bp_rd_count", rd_cnt, L0);

        // Contested port: grants alternate, processor first
        clr();
        cpu_req = 1'b1; cpu_addr = 18'h00777; cpu_we = 1'b1;
        kick(1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_gnt", int'(cpu_gnt), (i % 2 == 0) ? 1 : 0);
            chk("rr_addr", int'(mem_addr), (i % 2 == 0) ? 32'h777 : BASE + i / 2);
            chk("rr_we", int'(mem_we), (i % 2 == 0) ? 1 : 0);
        end
        wait_done(400);
        chk("rr_pix_count", pix_idx, L0);
        chk("rr_pix_err", pix_err, 0);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;

        // Abort with pixels queued, then restart from the base address
        clr();
        kick(1'b0);
        repeat (6) tick();
        pix_ready = 1'b0;
        repeat (3) tick();
        chk("ab_pre_valid", int'(pix_valid), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_valid", int'(pix_valid), 0);
        chk("ab_busy", int'(busy), 0);
        clr();
        repeat (10) tick();
        chk("ab_no_done", done_cnt, 0);
        chk("ab_no_reads", rd_cnt, 0);
        pix_ready = 1'b1;
        kick(1'b0);
        @(negedge clk);
        chk("ab_restart_addr", int'(mem_addr), BASE);
        wait_done(400);
        chk("ab_pix_count", pix_idx, L0);
        chk("ab_pix_err", pix_err, 0);

        // Asynchronous reset mid-frame, then start on the first edge
        clr();
        kick(1'b0);
        repeat (8) tick();
        cpu_req = 1'b1; cpu_addr = 18'h00555; cpu_we = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("ar_cpu_gnt", int'(cpu_gnt), 0);
        chk("ar_mem_addr", int'(mem_addr), 0);
        chk("ar_mem_we", int'(mem_we), 0);
        chk("ar_pix_valid", int'(pix_valid), 0);
        chk("ar_pix_data", int'(pix_data), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_done", int'(done), 0);
        tick();
        chk("ar_no_done", done_cnt, 0);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        rst = 1'b0;
        clr();
        kick(1'b0);
        chk("ar_start_busy", int'(busy), 1);
        wait_done(400);
        chk("ar_pix_count", pix_idx, L0);
        chk("ar_pix_err", pix_err, 0);
        chk("ar_done_count", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/output_stream_ctrl.md
OUTPUT_STREAM_CTRL -- requirements
Module: output_stream_ctrl

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 18, memory address width; BASE_ADDR, 160000, first pixel address of the output image.
REQ-002 Parameters: LEN0, 40000, pixel count when sel=0; LEN1, 88804, pixel count when sel=1; FIFO_D, 4, pixel FIFO depth.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to stream one frame.
REQ-006 sel  in  1  frame size select, sampled only when start is accepted.
REQ-007 abort  in  1  cancels an active frame.
REQ-008 cpu_req  in  1  processor requests the memory port this cycle.
REQ-009 cpu_addr  in  ADDR_W  processor address; cpu_we  in  1  processor write strobe.
REQ-010 cpu_gnt  out  1  processor owns the memory port this cycle (combinational).
REQ-011 mem_addr  out  ADDR_W  shared RAM address; mem_we  out  1  RAM write enable.
REQ-012 mem_rdata  in  8  RAM read data, valid exactly 1 cycle after the read address.
REQ-013 pix_data  out  8, pix_valid  out  1, pix_ready  in  1  pixel stream handshake toward the GPIO output.
REQ-014 busy  out  1  frame in progress; done  out  1  one-cycle frame-complete pulse.

Function
REQ-015 FSM states: IDLE, STREAM, DRAIN, DONE.
REQ-016 IDLE: start=1 latches sel, sets rd_addr=BASE_ADDR and remaining=LEN0 (sel=0) or LEN1 (sel=1), and moves to STREAM; start is ignored in any other state.
REQ-017 stream_req=1 only in STREAM, when remaining>0 and fifo_count+inflight<FIFO_D.
REQ-018 Arbitration: a lone requester is granted; when cpu_req and stream_req are both 1, grant alternates round-robin, with the processor first after reset.
REQ-019 In IDLE, DRAIN and DONE, cpu_req is granted unconditionally.
REQ-020 Processor grant: mem_addr=cpu_addr and mem_we=cpu_we.
REQ-021 Stream grant: mem_addr=rd_addr and mem_we=0; rd_addr increments by 1 and remaining decrements by 1; inflight is set for 1 cycle.
REQ-022 No grant: mem_addr=0 and mem_we=0.
REQ-023 Cycle after a stream read: mem_rdata is written into the FIFO, with no bubble.
REQ-024 FIFO count never exceeds FIFO_D because of the credit rule in REQ-017; overflow is not possible.
REQ-025 pix_valid = FIFO not empty; pix_data = FIFO head.
REQ-026 A pixel is popped on pix_valid & pix_ready; push and pop in the same cycle leave the count unchanged.
REQ-027 STREAM -> DRAIN when remaining reaches 0.
REQ-028 DRAIN -> DONE when inflight=0 and the FIFO is empty.
REQ-029 DONE asserts done for exactly 1 cycle, then moves to IDLE.
REQ-030 busy=1 in STREAM and DRAIN.
REQ-031 abort in STREAM or DRAIN: next cycle state=IDLE, FIFO flushed, any in-flight return discarded, no done pulse; abort in IDLE or DONE has no effect.
REQ-032 abort and start together in IDLE: start wins.
REQ-033 Pixel order equals address order BASE_ADDR.. BASE_ADDR+LEN-1; the total pixel count per completed frame equals LEN exactly.
REQ-034 rd_addr is never driven beyond BASE_ADDR+LEN-1.

Reset
REQ-035 rst=1: state=IDLE, FIFO empty, inflight=0, round-robin pointer=processor.
REQ-036 rst=1 outputs: mem_addr=0, mem_we=0, cpu_gnt=0, pix_valid=0, pix_data=0, busy=0, done=0.
REQ-037 rst asserted mid-frame aborts immediately without a done pulse.
REQ-038 After rst deasserts, start is accepted on the first clock edge.

Verification
REQ-039 start with sel=0, pix_ready=1, cpu_req=0 -> 40000 pixels at addresses 160000..199999 in order, then done pulses once, busy=0.
REQ-040 start with sel=1 -> 88804 pixels; the last address is 248803 (0x3CBE3) and the address never reaches 0x3CBE4.
REQ-041 pix_ready=0 after start -> exactly 4 reads issued, pix_valid=1 with the first pixel stable; releasing pix_ready resumes reads with no lost or duplicated pixel.
REQ-042 cpu_req=1 continuously during STREAM -> grants alternate cpu/stream every cycle; cpu writes land at cpu_addr with mem_we=1; the frame still completes.
REQ-043 abort at pixel 100 with 3 pixels queued -> pix_valid=0 next cycle, no done, state IDLE; a following start restarts at 160000.
REQ-044 start asserted during STREAM, and rst pulsed at pixel 500 -> start is ignored; all outputs reach their reset values asynchronously and no done pulse occurs.
